hazard_forward_unit: RTL

- Hazard-detection and forwarding-control stage for the five-stage MIPS pipeline.
- Sits in ID and drives the 2-bit select inputs of the EX-stage 4:1 ALU-operand multiplexers and the ID-stage branch-comparator multiplexers.
- Raises pipeline stall for load-use and branch-operand hazards.
- Keeps its own shadow copy of destination-register info for EX, MEM and WB, and counts stall cycles.

---
 rtl/hazard_forward_unit_pkg.sv | 43 ++++
 rtl/hazard_forward_unit_fwd.sv | 35 +++
 rtl/hazard_forward_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/hazard_forward_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit_pkg
// Shared definitions for the ID-stage hazard/forwarding unit of the five-stage
// MIPS pipeline: operand-mux select codes, the shadow-pipeline entry types and
// the single "does this stage produce my source register" predicate that every
// comparator in the unit uses.
// -----------------------------------------------------------------------------
package hazard_forward_unit_pkg;

    localparam int SHD_REG_BITS = 5;

    // Operand-mux select codes, shared by the EX ALU muxes and ID branch muxes.
    localparam logic [1:0] SEL_RF     = 2'd0;
    localparam logic [1:0] SEL_EXMEM  = 2'd1;
    localparam logic [1:0] SEL_MEMWB  = 2'd2;
    localparam logic [1:0] SEL_POSTWB = 2'd3;

    typedef struct packed {
        logic [SHD_REG_BITS-1:0] dest;
        logic                    regWrite;
        logic                    memRead;
    } shadow_t;

    // The post-WB latch only needs to know who was written, not how.
    typedef struct packed {
        logic [SHD_REG_BITS-1:0] dest;
        logic                    regWrite;
    } post_t;

    localparam shadow_t SHADOW_BUBBLE = '0;

    // Keeps dest and regWrite, drops memRead: a match ignores producer type.
    localparam logic [SHD_REG_BITS+1:0] MATCH_MASK = {{SHD_REG_BITS{1'b1}}, 2'b10};

    // A stage supplies the source when it writes a non-zero register equal to
    // the source and the consuming instruction actually reads that source.
    function automatic logic stageMatch(shadow_t entry,
                                        logic [SHD_REG_BITS-1:0] src,
                                        logic used);
        return used && (src != '0) && ((entry & MATCH_MASK) == {src, 2'b10});
    endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd.sv
// -----------------------------------------------------------------------------
// fwd_match
// Per-source priority comparator. Given one source register and three shadow
// entries ordered nearest-first, returns the select of the nearest producer.
// Ports:
//   src        source register specifier
//   used       the instruction really reads src
//   nearEntry  nearest producer candidate  -> SEL_EXMEM on match
//   midEntry   next producer candidate     -> SEL_MEMWB on match
//   farEntry   farthest producer candidate -> SEL_POSTWB on match
//   sel        resulting 2-bit mux select (SEL_RF when nothing matches)
// -----------------------------------------------------------------------------
module fwd_match
    import hazard_forward_unit_pkg::*;
(
    input  logic [SHD_REG_BITS-1:0] src,
    input  logic                    used,
    input  shadow_t                 nearEntry,
    input  shadow_t                 midEntry,
    input  shadow_t                 farEntry,
    output logic [1:0]              sel
);

    always_comb begin
        sel = SEL_RF;
        if (stageMatch(nearEntry, src, used)) begin
            sel = SEL_EXMEM;
        end else if (stageMatch(midEntry, src, used)) begin
            sel = SEL_MEMWB;
        end else if (stageMatch(farEntry, src, used)) begin
            sel = SEL_POSTWB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
// ID-stage hazard detection and forwarding control. Tracks destination info of
// the instructions in EX, MEM and WB (plus the register written last cycle),
// drives the EX ALU-operand mux selects (registered, shown during the
// consumer's EX cycle), the ID branch-comparator selects (combinational) and
// the pipeline Stall, and counts stall cycles.
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   IdValid..IdFlush      decoded info of the instruction currently in ID
//   FwdASel, FwdBSel      EX operand mux selects (registered)
//   BrASel, BrBSel        ID branch comparator selects (combinational)
//   Stall                 hold PC and IF/ID, bubble into ID/EX
//   StallCount            number of Stall cycles since reset, wrapping
// -----------------------------------------------------------------------------
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_BITS = SHD_REG_BITS,
    parameter int CNT_BITS = 32
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                IdValid,
    input  logic [REG_BITS-1:0] IdRs,
    input  logic [REG_BITS-1:0] IdRt,
    input  logic                IdUsesRs,
    input  logic                IdUsesRt,
    input  logic                IdIsBranch,
    input  logic [REG_BITS-1:0] IdDest,
    input  logic                IdRegWrite,
    input  logic                IdMemRead,
    input  logic                IdFlush,
    output logic [1:0]          FwdASel,
    output logic [1:0]          FwdBSel,
    output logic [1:0]          BrASel,
    output logic [1:0]          BrBSel,
    output logic                Stall,
    output logic [CNT_BITS-1:0] StallCount
);

    shadow_t exShd_p1;
    shadow_t memShd_p2;
    shadow_t wbShd_p3;
    post_t   postShd_p4;

    shadow_t    idEntry;
    shadow_t    memBrEntry;
    logic [1:0] fwdARaw;
    logic [1:0] fwdBRaw;
    logic [1:0] brARaw;
    logic [1:0] brBRaw;
    logic       exHit;
    logic       memLoadHit;
    logic       loadEx;

    // ---- ID: hazard evaluation against the shadow pipeline ----
    always_comb begin
        idEntry          = '{dest: IdDest, regWrite: IdRegWrite, memRead: IdMemRead};
        // A load in MEM has no value on the EX/MEM bus yet, so the branch
        // comparator must not pick it; the stall covers that case instead.
        memBrEntry       = memShd_p2;
        if (memShd_p2.memRead) begin
            memBrEntry.regWrite = 1'b0;
        end
    end

    fwd_match uFwdA (
        .src(IdRs), .used(IdUsesRs),
        .nearEntry(exShd_p1), .midEntry(memShd_p2), .farEntry(wbShd_p3),
        .sel(fwdARaw)
    );

    fwd_match uFwdB (
        .src(IdRt), .used(IdUsesRt),
        .nearEntry(exShd_p1), .midEntry(memShd_p2), .farEntry(wbShd_p3),
        .sel(fwdBRaw)
    );

    // The branch compares in ID, so its nearest usable producer is MEM (sel 1)
    // and then WB (sel 2); there is no post-WB path for the comparator.
    fwd_match uBrA (
        .src(IdRs), .used(IdUsesRs),
        .nearEntry(memBrEntry), .midEntry(wbShd_p3), .farEntry(SHADOW_BUBBLE),
        .sel(brARaw)
    );

    fwd_match uBrB (
        .src(IdRt), .used(IdUsesRt),
        .nearEntry(memBrEntry), .midEntry(wbShd_p3), .farEntry(SHADOW_BUBBLE),
        .sel(brBRaw)
    );

    always_comb begin
        // EX-forward comparator returns SEL_EXMEM exactly when EX matches.
        exHit      = (fwdARaw == SEL_EXMEM) || (fwdBRaw == SEL_EXMEM);
        memLoadHit = memShd_p2.memRead &&
                     (stageMatch(memShd_p2, IdRs, IdUsesRs) ||
                      stageMatch(memShd_p2, IdRt, IdUsesRt));
        Stall      = IdValid &&
                     ((exHit && (exShd_p1.memRead || IdIsBranch)) ||
                      (IdIsBranch && memLoadHit));
        // Stall outranks a concurrent flush: the held instruction stays live.
        loadEx     = IdValid && !Stall && !IdFlush;
        BrASel     = IdIsBranch ? brARaw : SEL_RF;
        BrBSel     = IdIsBranch ? brBRaw : SEL_RF;
    end

    // ---- ID/EX boundary: shadow pipeline advance, forward selects, counter ----
    always_ff @(posedge Clk) begin
        if (Reset) begin
            exShd_p1   <= SHADOW_BUBBLE;
            memShd_p2  <= SHADOW_BUBBLE;
            wbShd_p3   <= SHADOW_BUBBLE;
            postShd_p4 <= '0;
            FwdASel    <= SEL_RF;
            FwdBSel    <= SEL_RF;
            StallCount <= '0;
        end else begin
            exShd_p1   <= loadEx ? idEntry : SHADOW_BUBBLE;
            memShd_p2  <= exShd_p1;
            wbShd_p3   <= memShd_p2;
            postShd_p4 <= '{dest: wbShd_p3.dest, regWrite: wbShd_p3.regWrite};
            FwdASel    <= loadEx ? fwdARaw : SEL_RF;
            FwdBSel    <= loadEx ? fwdBRaw : SEL_RF;
            StallCount <= StallCount + {{(CNT_BITS-1){1'b0}}, Stall};
        end
    end

    // A post-WB select is only meaningful if the post latch holds a real write.
    postWbLive: assert property (@(posedge Clk) disable iff (Reset)
        ((FwdASel == SEL_POSTWB) || (FwdBSel == SEL_POSTWB)) |->
        (postShd_p4.regWrite && (postShd_p4.dest != '0)));

endmodule
